// File: rtl/dmem_responder.sv
// Purpose : word-organised little-endian data RAM behind a one-at-a-time load/store request port.
// Latency : resp_valid rises WAIT_CYCLES+1 cycles after the accepting edge; RAM commit on the edge entering RESP.
// Backpr. : req_ready only in IDLE; the response is held (data/err stable) until resp_ready.
//
// Ports:
//   clk, rst_n                       clock; synchronous active-low reset
//   req_valid / req_ready            request handshake
//   req_we, req_size, req_unsigned   store/load, 00 byte 01 half 10 word 11 illegal, zero-extend select
//   req_addr, req_wdata              byte address, right-aligned store data
//   resp_valid / resp_ready          response handshake
//   resp_rdata, resp_err             extended load data (0 for stores/errors), misaligned/illegal flag
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [1:0] SZ_B      = 2'b00;
    localparam logic [1:0] SZ_H      = 2'b01;
    localparam logic [1:0] SZ_W      = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;

    // Captured request
    logic              q_we;
    logic [1:0]        q_size;
    logic              q_unsigned;
    logic [ADDR_W-1:0] q_addr;
    logic [31:0]       q_wdata;

    logic [31:0]       mem [DEPTH];

    // Fields used at the commit edge. With zero wait states the commit edge is
    // the accepting edge, so the live request is used instead of the capture.
    logic              c_we;
    logic [1:0]        c_size;
    logic              c_unsigned;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;

    always_comb begin
        if (state == S_IDLE) begin
            c_we       = req_we;
            c_size     = req_size;
            c_unsigned = req_unsigned;
            c_addr     = req_addr;
            c_wdata    = req_wdata;
        end else begin
            c_we       = q_we;
            c_size     = q_size;
            c_unsigned = q_unsigned;
            c_addr     = q_addr;
            c_wdata    = q_wdata;
        end
    end

    logic [1:0]        c_lane;
    logic [ADDR_W-3:0] c_idx;
    logic              commit;

    assign c_lane = c_addr[1:0];
    assign c_idx  = c_addr[ADDR_W-1:2];

    // Reset has priority: a store whose commit edge coincides with reset is dropped.
    assign commit = rst_n &&
                    (((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd1)));

    // Misalignment / illegal size
    logic c_err;

    always_comb begin
        case (c_size)
            SZ_B:    c_err = 1'b0;
            SZ_H:    c_err = c_lane[0];
            SZ_W:    c_err = |c_lane;
            default: c_err = 1'b1;
        endcase
    end

    // Store byte strobes and lane-replicated write data
    logic [3:0]  c_strb;
    logic [31:0] c_wword;

    always_comb begin
        c_strb  = 4'b0000;
        c_wword = c_wdata;
        case (c_size)
            SZ_B: begin
                c_strb  = 4'b0001 << c_lane;
                c_wword = {4{c_wdata[7:0]}};
            end
            SZ_H: begin
                c_strb  = c_lane[1] ? 4'b1100 : 4'b0011;
                c_wword = {2{c_wdata[15:0]}};
            end
            SZ_W:    c_strb = 4'b1111;
            default: c_strb = 4'b0000;
        endcase
        if (!c_we || c_err) begin
            c_strb = 4'b0000;
        end
    end

    // RAM contents survive reset on purpose: committed stores are kept.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (c_strb[i]) begin
                    mem[c_idx][i*8 +: 8] <= c_wword[i*8 +: 8];
                end
            end
        end
    end

    // Load extraction and extension
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_val;

    assign rd_word = mem[c_idx];

    always_comb begin
        rd_byte = rd_word[{c_lane, 3'b000} +: 8];
        rd_half = c_lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (c_size)
            SZ_B:    ld_val = {{24{rd_byte[7] & ~c_unsigned}}, rd_byte};
            SZ_H:    ld_val = {{16{rd_half[15] & ~c_unsigned}}, rd_half};
            default: ld_val = rd_word;
        endcase
        if (c_we || c_err) begin
            ld_val = 32'h0;
        end
    end

    // Control FSM. RESP spends its first cycle with resp_valid low so the
    // response appears one cycle after the commit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            q_we       <= 1'b0;
            q_size     <= 2'b00;
            q_unsigned <= 1'b0;
            q_addr     <= '0;
            q_wdata    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        q_we       <= req_we;
                        q_size     <= req_size;
                        q_unsigned <= req_unsigned;
                        q_addr     <= req_addr;
                        q_wdata    <= req_wdata;
                        cnt        <= WAIT_INIT;
                        req_ready  <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= S_RESP;
                            resp_rdata <= ld_val;
                            resp_err   <= c_err;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= S_RESP;
                        resp_rdata <= ld_val;
                        resp_err   <= c_err;
                    end
                end
                S_RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int W_A = 1;
    localparam int W_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (WAIT_CYCLES = 1)
    logic        rst_n        = 1'b0;
    logic        req_valid    = 1'b0;
    logic        req_ready;
    logic        req_we       = 1'b0;
    logic [1:0]  req_size     = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [7:0]  req_addr     = 8'h00;
    logic [31:0] req_wdata    = 32'h0;
    logic        resp_valid;
    logic        resp_ready   = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Second instance (WAIT_CYCLES = 3) for the reset-abort scenarios
    logic        b_rst_n        = 1'b0;
    logic        b_req_valid    = 1'b0;
    logic        b_req_ready;
    logic        b_req_we       = 1'b0;
    logic [1:0]  b_req_size     = 2'b10;
    logic        b_req_unsigned = 1'b0;
    logic [7:0]  b_req_addr     = 8'h00;
    logic [31:0] b_req_wdata    = 32'h0;
    logic        b_resp_valid;
    logic        b_resp_ready   = 1'b1;
    logic [31:0] b_resp_rdata;
    logic        b_resp_err;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(W_A)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(W_B)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // ------------------------------------------------------------------
    // Reference model of the main instance: a byte-addressed word array,
    // one outstanding request, response due W_A+1 edges after acceptance.
    // ------------------------------------------------------------------
    logic [31:0] m_mem [64];
    int          cyc  = 0;
    bit          pend = 1'b0;
    int          rise = 0;
    logic [31:0] e_rdata = 32'h0;
    logic        e_err   = 1'b0;

    task automatic model_exec(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [7:0] a, input logic [31:0] wd);
        int          idx;
        int          lane;
        logic [31:0] w;
        logic [31:0] v;
        idx     = int'(a) / 4;
        lane    = int'(a) % 4;
        e_err   = (sz == 2'd3) || (sz == 2'd1 && (lane % 2) != 0) || (sz == 2'd2 && lane != 0);
        e_rdata = 32'h0;
        if (e_err) return;
        if (we) begin
            w = m_mem[idx];
            for (int b = 0; b < (1 << sz); b++) w[(lane + b) * 8 +: 8] = wd[b * 8 +: 8];
            m_mem[idx] = w;
        end else begin
            v = m_mem[idx] >> (8 * lane);
            if (sz == 2'd0)      v = (!uns && v[7])  ? (v | 32'hFFFFFF00) : (v & 32'h000000FF);
            else if (sz == 2'd1) v = (!uns && v[15]) ? (v | 32'hFFFF0000) : (v & 32'h0000FFFF);
            e_rdata = v;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else if (pend) begin
            if (cyc >= rise && resp_ready) pend = 1'b0;
        end else if (req_valid) begin
            pend = 1'b1;
            rise = cyc + 1 + W_A + 1;
            model_exec(req_we, req_size, req_unsigned, req_addr, req_wdata);
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = pend && (cyc >= rise);
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
            chk("req_ready", {31'b0, req_ready}, {31'b0, !pend});
            if (ev) begin
                chk("resp_rdata", resp_rdata, e_rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid) break;
        end
        if (!resp_valid) timeout("resp_wait");
        rd = resp_rdata;
        er = resp_err;
        if (resp_ready) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [7:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        n            = 0;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout("accept_wait");
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        wait_resp(lat, rd, er);
    endtask

    task automatic b_do(input logic we, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
        b_req_we    = we;
        b_req_size  = 2'b10;
        b_req_addr  = a;
        b_req_wdata = wd;
        b_req_valid = 1'b1;
        @(negedge clk);
        if (!b_req_ready) timeout("b_accept");
        @(posedge clk);
        #2;
        b_req_valid = 1'b0;
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (b_resp_valid) break;
        end
        if (!b_resp_valid) timeout("b_resp_wait");
        rd = b_resp_rdata;
        @(posedge clk);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("b_rst_req_ready", {31'b0, b_req_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        b_rst_n = 1'b1;

        // Give every word a defined value
        for (int i = 0; i < 64; i++) do_req(1'b1, 2'd2, 1'b0, 8'(i * 4), $urandom, rd, er, lat);

        // 1: word store / load and latency
        do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'h11223344, rd, er, lat);
        chk("t1_sw_lat", lat, W_A + 1);
        chk("t1_sw_rdata", rd, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, rd, er, lat);
        chk("t1_lw_rdata", rd, 32'h11223344);
        chk("t1_lw_err", {31'b0, er}, 32'd0);
        chk("t1_lw_lat", lat, W_A + 1);

        // 2: byte lane merge
        do_req(1'b1, 2'd2, 1'b0, 8'h04, 32'h00000000, rd, er, lat);
        do_req(1'b1, 2'd0, 1'b0, 8'h05, 32'h000000AB, rd, er, lat);
        do_req(1'b0, 2'd2, 1'b0, 8'h04, 32'h0, rd, er, lat);
        chk("t2_lw", rd, 32'h0000AB00);
        do_req(1'b0, 2'd1, 1'b0, 8'h06, 32'h0, rd, er, lat);
        chk("t2_lh_hi", rd, 32'h00000000);

        // 3: sign / zero extension
        do_req(1'b1, 2'd0, 1'b0, 8'h08, 32'h00000080, rd, er, lat);
        do_req(1'b0, 2'd0, 1'b0, 8'h08, 32'h0, rd, er, lat);
        chk("t3_lb", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 8'h08, 32'h0, rd, er, lat);
        chk("t3_lbu", rd, 32'h00000080);
        do_req(1'b1, 2'd1, 1'b0, 8'h0A, 32'h00008001, rd, er, lat);
        do_req(1'b0, 2'd1, 1'b0, 8'h0A, 32'h0, rd, er, lat);
        chk("t3_lh", rd, 32'hFFFF8001);
        do_req(1'b0, 2'd1, 1'b1, 8'h0A, 32'h0, rd, er, lat);
        chk("t3_lhu", rd, 32'h00008001);

        // 4: error cases leave RAM untouched
        do_req(1'b1, 2'd2, 1'b0, 8'h00, 32'h55667788, rd, er, lat);
        do_req(1'b1, 2'd2, 1'b0, 8'h02, 32'hFFFFFFFF, rd, er, lat);
        chk("t4_sw_mis_err", {31'b0, er}, 32'd1);
        chk("t4_sw_mis_lat", lat, W_A + 1);
        do_req(1'b0, 2'd1, 1'b0, 8'h03, 32'h0, rd, er, lat);
        chk("t4_lh_mis_err", {31'b0, er}, 32'd1);
        chk("t4_lh_mis_rdata", rd, 32'h0);
        do_req(1'b1, 2'd3, 1'b0, 8'h00, 32'hFFFFFFFF, rd, er, lat);
        chk("t4_size11_err", {31'b0, er}, 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 8'h00, 32'h0, rd, er, lat);
        chk("t4_lw_unchanged", rd, 32'h55667788);

        // 5: response held under backpressure, no accept in release cycle
        resp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, rd, er, lat);
        chk("t5_rdata", rd, 32'h11223344);
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 8'h04;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t5_hold_valid", {31'b0, resp_valid}, 32'd1);
            chk("t5_hold_rdata", resp_rdata, 32'h11223344);
            chk("t5_hold_err", {31'b0, resp_err}, 32'd0);
            chk("t5_hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rel_valid", {31'b0, resp_valid}, 32'd0);
        chk("t5_rel_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        @(negedge clk);
        chk("t5_second_accepted", {31'b0, req_ready}, 32'd0);
        wait_resp(lat, rd, er);
        chk("t5_second_rdata", rd, 32'h0000AB00);
        chk("t5_second_lat", lat, W_A + 1);

        // Randomised traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            req_valid    = 1'($urandom_range(0, 1));
            req_we       = 1'($urandom_range(0, 1));
            req_size     = 2'($urandom_range(0, 3));
            req_unsigned = 1'($urandom_range(0, 1));
            req_addr     = 8'($urandom);
            req_wdata    = $urandom;
            resp_ready   = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #2;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;

        // 6: reset during WAIT discards the store (WAIT_CYCLES = 3)
        b_do(1'b1, 8'h20, 32'h12345678, rd, lat);
        chk("t6_sw_lat", lat, W_B + 1);
        b_req_we    = 1'b1;
        b_req_addr  = 8'h20;
        b_req_wdata = 32'hDEADBEEF;
        b_req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        b_req_valid = 1'b0;
        @(posedge clk);
        #2;
        b_rst_n = 1'b0;
        @(posedge clk);
        #2;
        b_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_resp", {31'b0, b_resp_valid}, 32'd0);
            chk("t6_idle", {31'b0, b_req_ready}, 32'd1);
            @(posedge clk);
            #2;
        end
        b_do(1'b0, 8'h20, 32'h0, rd, lat);
        chk("t6_lw_pre", rd, 32'h12345678);

        // Reset while holding RESP keeps the committed store
        b_resp_ready = 1'b0;
        b_req_we     = 1'b1;
        b_req_addr   = 8'h20;
        b_req_wdata  = 32'hCAFEF00D;
        b_req_valid  = 1'b1;
        @(posedge clk);
        #2;
        b_req_valid = 1'b0;
        for (int n = 0; n < 20 && !b_resp_valid; n++) begin
            @(posedge clk);
            #2;
        end
        chk("t6r_resp_seen", {31'b0, b_resp_valid}, 32'd1);
        b_rst_n = 1'b0;
        @(posedge clk);
        #2;
        b_rst_n      = 1'b1;
        b_resp_ready = 1'b1;
        @(negedge clk);
        chk("t6r_valid_cleared", {31'b0, b_resp_valid}, 32'd0);
        @(posedge clk);
        #2;
        b_do(1'b0, 8'h20, 32'h0, rd, lat);
        chk("t6r_lw_kept", rd, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
